// File: rtl/grf_sb.sv
// grf_sb: general-purpose register file with NUM_RD combinational read ports,
// one write port, and a per-register busy scoreboard for the hazard unit.
// Register 0 is hardwired to zero and is never busy.
// Optional macro GRF_BYPASS_EN forwards same-cycle write data to matching reads.
module grf_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*ADDR_W-1:0] raddr,
   output logic [NUM_RD*DATA_W-1:0] rdata,
   output logic [NUM_RD-1:0]        rbusy,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic                     iss_valid,
   input  logic [ADDR_W-1:0]        iss_addr,
   output logic [ADDR_W:0]          busy_cnt
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  busy;

   logic wr_en;
   logic iss_en;
   logic set_new;
   logic clr;

   // Qualify writes/issues (register 0 drops both) and classify the counter change.
   always_comb begin
      wr_en   = we && (waddr != '0);
      iss_en  = iss_valid && (iss_addr != '0);
      // Only a 0->1 transition grows the population.
      set_new = iss_en && !busy[iss_addr];
      // A same-register issue overrides the clear: the new producer wins.
      clr     = wr_en && busy[waddr] && !(iss_en && (iss_addr == waddr));
   end

   // Storage, busy bits and busy count; synchronous reset overrides all activity.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         if (wr_en) begin
            mem[waddr] <= wdata;
         end
         if (clr) begin
            busy[waddr] <= 1'b0;
         end
         if (iss_en) begin
            busy[iss_addr] <= 1'b1;
         end
         if (set_new && !clr) begin
            busy_cnt <= busy_cnt + (ADDR_W + 1)'(1);
         end else if (clr && !set_new) begin
            busy_cnt <= busy_cnt - (ADDR_W + 1)'(1);
         end
      end
   end

   // Combinational read ports; rbusy always reflects the registered busy bits.
   always_comb begin
      rdata = '0;
      rbusy = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         rdata[i*DATA_W +: DATA_W] = mem[raddr[i*ADDR_W +: ADDR_W]];
`ifdef GRF_BYPASS_EN
         if (wr_en && (raddr[i*ADDR_W +: ADDR_W] == waddr)) begin
            rdata[i*DATA_W +: DATA_W] = wdata;
         end
`endif
         rbusy[i] = busy[raddr[i*ADDR_W +: ADDR_W]];
      end
   end

endmodule

// File: tb/tb_grf_sb.sv
// tb_grf_sb: directed self-checking bench for grf_sb, default build plus a
// NUM_RD=4 / ADDR_W=4 instance.
module tb_grf_sb;

`ifdef GRF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Instance A: defaults (32-bit, 32 regs, 2 read ports)
   logic        a_reset;
   logic [9:0]  a_raddr;
   logic [63:0] a_rdata;
   logic [1:0]  a_rbusy;
   logic        a_we;
   logic [4:0]  a_waddr;
   logic [31:0] a_wdata;
   logic        a_iss_valid;
   logic [4:0]  a_iss_addr;
   logic [5:0]  a_busy_cnt;

   grf_sb u_a (
      .clk       (clk),
      .reset     (a_reset),
      .raddr     (a_raddr),
      .rdata     (a_rdata),
      .rbusy     (a_rbusy),
      .we        (a_we),
      .waddr     (a_waddr),
      .wdata     (a_wdata),
      .iss_valid (a_iss_valid),
      .iss_addr  (a_iss_addr),
      .busy_cnt  (a_busy_cnt)
   );

   // Instance B: 16 regs, 4 read ports
   logic         b_reset;
   logic [15:0]  b_raddr;
   logic [127:0] b_rdata;
   logic [3:0]   b_rbusy;
   logic         b_we;
   logic [3:0]   b_waddr;
   logic [31:0]  b_wdata;
   logic         b_iss_valid;
   logic [3:0]   b_iss_addr;
   logic [4:0]   b_busy_cnt;

   grf_sb #(
      .DATA_W (32),
      .ADDR_W (4),
      .NUM_RD (4)
   ) u_b (
      .clk       (clk),
      .reset     (b_reset),
      .raddr     (b_raddr),
      .rdata     (b_rdata),
      .rbusy     (b_rbusy),
      .we        (b_we),
      .waddr     (b_waddr),
      .wdata     (b_wdata),
      .iss_valid (b_iss_valid),
      .iss_addr  (b_iss_addr),
      .busy_cnt  (b_busy_cnt)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      a_reset = 1'b1; a_we = 1'b1; a_waddr = 5'd3; a_wdata = 32'h1234;
      a_iss_valid = 1'b0; a_iss_addr = '0; a_raddr = {5'd3, 5'd3};
      b_reset = 1'b1; b_we = 1'b0; b_waddr = '0; b_wdata = '0;
      b_iss_valid = 1'b0; b_iss_addr = '0; b_raddr = '0;

      // Reset for two cycles with a write pending: it must be dropped
      tick();
      tick();
      a_reset = 1'b0; a_we = 1'b0; b_reset = 1'b0;
      #1;
      check("rst_rdata0", a_rdata[31:0], 64'h0);
      check("rst_rdata1", a_rdata[63:32], 64'h0);
      check("rst_rbusy", a_rbusy, 64'h0);
      check("rst_cnt", a_busy_cnt, 64'h0);

      // Write reg 5 and read it in the same cycle
      a_we = 1'b1; a_waddr = 5'd5; a_wdata = 32'hDEADBEEF; a_raddr = {5'd5, 5'd5};
      #1;
      check("wr_same_cycle", a_rdata[31:0], BYP ? 64'hDEADBEEF : 64'h0);
      tick();
      a_we = 1'b0;
      #1;
      check("wr_next_p0", a_rdata[31:0], 64'hDEADBEEF);
      check("wr_next_p1", a_rdata[63:32], 64'hDEADBEEF);

      // Register 0: write and issue both dropped
      a_we = 1'b1; a_waddr = 5'd0; a_wdata = 32'hFFFFFFFF;
      a_iss_valid = 1'b1; a_iss_addr = 5'd0; a_raddr = {5'd0, 5'd0};
      #1;
      check("r0_same_cycle", a_rdata[31:0], 64'h0);
      tick();
      a_we = 1'b0; a_iss_valid = 1'b0;
      #1;
      check("r0_rdata", a_rdata[31:0], 64'h0);
      check("r0_rbusy", a_rbusy, 64'h0);
      check("r0_cnt", a_busy_cnt, 64'h0);

      // Scoreboard lifecycle: issue 4, 7, 9
      a_iss_valid = 1'b1; a_iss_addr = 5'd4; tick();
      check("iss4_cnt", a_busy_cnt, 64'd1);
      a_iss_addr = 5'd7; tick();
      check("iss7_cnt", a_busy_cnt, 64'd2);
      a_iss_addr = 5'd9; tick();
      check("iss9_cnt", a_busy_cnt, 64'd3);
      a_iss_valid = 1'b0; a_we = 1'b1; a_waddr = 5'd7; a_wdata = 32'h77;
      tick();
      a_we = 1'b0; a_raddr = {5'd4, 5'd7};
      #1;
      check("wr7_cnt", a_busy_cnt, 64'd2);
      check("wr7_rbusy", a_rbusy, 64'b10);
      check("wr7_rdata", a_rdata[31:0], 64'h77);

      // Same-cycle issue and write on reg 4: stays busy
      a_iss_valid = 1'b1; a_iss_addr = 5'd4; a_we = 1'b1; a_waddr = 5'd4; a_wdata = 32'h44;
      tick();
      a_iss_valid = 1'b0; a_we = 1'b0;
      #1;
      check("setclr_same_rbusy", a_rbusy, 64'b10);
      check("setclr_same_cnt", a_busy_cnt, 64'd2);

      // Issue 10 while writing 4; rbusy not bypassed before the edge
      a_iss_valid = 1'b1; a_iss_addr = 5'd10; a_we = 1'b1; a_waddr = 5'd4; a_wdata = 32'h55;
      a_raddr = {5'd10, 5'd4};
      #1;
      check("setclr_pre_rbusy", a_rbusy, 64'b01);
      tick();
      a_iss_valid = 1'b0; a_we = 1'b0;
      #1;
      check("setclr_diff_rbusy", a_rbusy, 64'b10);
      check("setclr_diff_cnt", a_busy_cnt, 64'd2);
      check("setclr_diff_rdata", a_rdata[31:0], 64'h55);

      // Write to a non-busy register leaves busy clear
      a_we = 1'b1; a_waddr = 5'd20; a_wdata = 32'h2020; tick();
      a_we = 1'b0; a_raddr = {5'd20, 5'd20};
      #1;
      check("wr_free_cnt", a_busy_cnt, 64'd2);
      check("wr_free_rbusy", a_rbusy, 64'b00);
      a_iss_valid = 1'b1; a_iss_addr = 5'd12; tick();
      check("iss12_cnt", a_busy_cnt, 64'd3);

      // Reset mid-operation together with an issue
      a_reset = 1'b1; a_iss_addr = 5'd13; tick();
      a_reset = 1'b0; a_iss_valid = 1'b0; a_raddr = {5'd5, 5'd4};
      #1;
      check("midrst_cnt", a_busy_cnt, 64'd0);
      check("midrst_data", a_rdata, 64'h0);
      a_raddr = {5'd12, 5'd20};
      #1;
      check("midrst_rbusy", a_rbusy, 64'b00);
      check("midrst_data20", a_rdata[31:0], 64'h0);

      // Instance B: fill every register with issue+write on the same reg
      for (int r = 1; r < 16; r++) begin
         b_iss_valid = 1'b1; b_iss_addr = 4'(r);
         b_we = 1'b1; b_waddr = 4'(r); b_wdata = 32'(r) * 32'h111;
         tick();
      end
      b_we = 1'b0; b_iss_valid = 1'b0;
      #1;
      check("b_full_cnt", b_busy_cnt, 64'd15);
      b_iss_valid = 1'b1; b_iss_addr = 4'd15; tick();
      b_iss_valid = 1'b0;
      check("b_reissue_cnt", b_busy_cnt, 64'd15);
      b_raddr = {4'd15, 4'd2, 4'd1, 4'd0};
      #1;
      check("b_rd3", b_rdata[127:96], 64'hFFF);
      check("b_rd2", b_rdata[95:64], 64'h222);
      check("b_rd1", b_rdata[63:32], 64'h111);
      check("b_rd0", b_rdata[31:0], 64'h0);
      check("b_rbusy", b_rbusy, 64'b1110);
      b_raddr = {4'd7, 4'd7, 4'd7, 4'd7};
      #1;
      check("b_same_lo", b_rdata[63:0], 64'h00000777_00000777);
      check("b_same_hi", b_rdata[127:64], 64'h00000777_00000777);

      // Instance B: reset mid-operation with issue and write pending
      b_reset = 1'b1; b_iss_valid = 1'b1; b_iss_addr = 4'd3;
      b_we = 1'b1; b_waddr = 4'd3; b_wdata = 32'hABCD;
      tick();
      b_reset = 1'b0; b_iss_valid = 1'b0; b_we = 1'b0;
      b_raddr = {4'd15, 4'd3, 4'd2, 4'd7};
      #1;
      check("b_rst_cnt", b_busy_cnt, 64'd0);
      check("b_rst_rbusy", b_rbusy, 64'b0000);
      check("b_rst_lo", b_rdata[63:0], 64'h0);
      check("b_rst_hi", b_rdata[127:64], 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/grf_sb.md
# grf_sb

Parametrised general-purpose register file for the pipelined MIPS core. It adds a configurable number of read ports and a per-register busy scoreboard for the hazard unit. An optional write-to-read bypass is also included. It replaces the fixed 2-read/1-write 32×32 file in the decode stage: writes commit in the writeback stage, reads and busy queries serve decode.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (1..4)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- raddr  input  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rdata  output  NUM_RD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W]
- rbusy  output  NUM_RD  bit i = busy bit of raddr port i
- we  input  1  write enable (writeback)
- waddr  input  ADDR_W  write address
- wdata  input  DATA_W  write data
- iss_valid  input  1  an instruction with a register destination issues this cycle
- iss_addr  input  ADDR_W  destination of the issuing instruction
- busy_cnt  output  ADDR_W+1  number of registers currently marked busy

## Operation
- Storage: 2**ADDR_W × DATA_W registers plus 2**ADDR_W busy bits.
- Register 0 is hardwired:
  - Always reads 0 and is never busy.
  - Writes to it are discarded, as are issues that target it.
- Write:
  - When we=1 and waddr≠0, mem[waddr] ← wdata at the edge.
  - When we=0, storage is unchanged.
- Read:
  - Combinational. rdata_i = mem[raddr_i], subject to register 0 and the bypass (see Configuration).
- Scoreboard, per register r≠0, at each edge:
  - Set when iss_valid=1 and iss_addr=r.
  - Cleared when we=1 and waddr=r, unless it is also being set.
  - Set and clear in the same cycle on the same r: busy stays 1, because the new producer wins.
  - Issuing to an already-busy register is legal; the busy bit stays 1. In-order commit means the next write to that register clears it.
  - A write to a non-busy register is legal and leaves busy=0.
- rbusy_i is combinational from the registered busy bits. It is not bypassed: the same-cycle issue or write takes effect next cycle.
- busy_cnt:
  - Registered population count of the busy bits, updated in the same edge as they are.
  - Net change per cycle is one of −1, 0, +1:
    - +1 when a new bit is set and none cleared.
    - −1 when a bit is cleared and none set.
    - 0 when both happen on different registers, or on the same register.
  - Range is 0..2**ADDR_W−1; it never wraps.
- Reset:
  - All registers ← 0, all busy ← 0, busy_cnt ← 0.
  - we and iss_valid are ignored in a reset cycle, including mid-operation with pending busy bits.

## Timing
- Read latency is 0 cycles (combinational address-to-data).
- Write is visible in storage the cycle after we is sampled. With the bypass, it is also visible combinationally in the same cycle.
- Busy and busy_cnt update 1 cycle after iss_valid or we is sampled.
- Reset values of outputs:
  - rdata = 0 for all ports (memory cleared, bypass inactive unless we is asserted).
  - rbusy = 0.
  - busy_cnt = 0.
- Multiple read ports may use the same address; each returns identical data.

## Configuration
- GRF_BYPASS_EN defined:
  - When we=1, waddr≠0 and raddr_i=waddr, rdata_i = wdata in the same cycle (internal forwarding).
  - The external forwarding network then needs no writeback-to-decode path.
- GRF_BYPASS_EN undefined:
  - rdata_i always equals stored mem[raddr_i].
  - Data written at edge N is readable only after edge N.
- The scoreboard and busy_cnt are identical in both builds.

## Test plan
- Reset then read: assert reset for 2 cycles with we=1, waddr=3, wdata=32'h1234 -> all rdata=0, mem[3] still 0, rbusy=0, busy_cnt=0.
- Write and read-back: we=1, waddr=5, wdata=32'hDEADBEEF, raddr0=5 in the same cycle ->
  - bypass build: rdata0=32'hDEADBEEF in that cycle.
  - no-bypass build: old value (0) in that cycle, 32'hDEADBEEF from the next cycle on.
- Register 0: we=1, waddr=0, wdata=32'hFFFFFFFF, iss_valid=1, iss_addr=0 -> rdata for raddr=0 is 0 in both builds; rbusy=0; busy_cnt unchanged.
- Scoreboard lifecycle: issue to regs 4, 7, 9 in three consecutive cycles -> busy_cnt 1, 2, 3. Then write reg 7 -> busy_cnt=2, rbusy for raddr=7 is 0, for raddr=4 is 1.
- Simultaneous set and clear:
  - Reg 4 busy; iss_valid=1, iss_addr=4 and we=1, waddr=4 in the same cycle -> reg 4 remains busy, busy_cnt unchanged.
  - Reg 4 busy; same-cycle issue to 10 and write to 4 -> busy_cnt unchanged, reg 10 busy, reg 4 free.
- Reset mid-operation: with busy_cnt=3 and regs holding nonzero data, assert reset one cycle together with iss_valid=1 -> next cycle busy_cnt=0, all rbusy=0, all rdata=0. Repeat with NUM_RD=4, ADDR_W=4.
